// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and helpers for the weighted round-robin arbiter
//
// Purpose: arbiter FSM state encoding and the effective-weight helper.
// Ports: none (package).
package arb_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } arb_state_e;

  // A weight of zero would starve its owner of any transfer, so it is promoted to one.
  function automatic int unsigned weff(input int unsigned w);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/priority_pick.sv
// rtl/priority_pick.sv - lowest-set-bit picker with one-hot and encoded outputs
//
// Purpose: picks the lowest-index set bit of req_i.
// Ports:
//   req_i    in  N              candidate request vector
//   onehot_o out N              one-hot of the lowest set bit, zero if none
//   enc_o    out $clog2(N)+1    index of the lowest set bit, all-ones if none
//   valid_o  out 1              any bit of req_i set
module priority_pick #(
  parameter int N = 8
) (
  input  logic [N-1:0]       req_i,
  output logic [N-1:0]       onehot_o,
  output logic [$clog2(N):0] enc_o,
  output logic               valid_o
);

  localparam int EncWidth = $clog2(N) + 1;

  // Two's-complement trick isolates the lowest set bit.
  assign onehot_o = req_i & (~req_i + N'(1));
  assign valid_o  = |req_i;

  // Scan downward so the lowest set index is the last one written.
  always_comb begin
    enc_o = '1;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        enc_o = EncWidth'(i);
      end
    end
  end

endmodule

// File: rtl/weighted_rr_arbiter.sv
// rtl/weighted_rr_arbiter.sv - registered weighted round-robin arbiter with grant hold and lock
//
// Purpose: the owner keeps the grant for up to weight[i] acked transfers, then priority
// rotates past it; lock[owner] holds the grant indefinitely.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   ce           clock enable, all state frozen when low
//   req          per-requester level request
//   lock         lock[owner] holds the grant regardless of credit
//   weight       per-requester weight, field i = weight[i*WeightWidth +: WeightWidth]
//   ack          owner completed one transfer this cycle
//   grant_valid  a grant is active
//   grant        registered one-hot grant
//   grant_enc    encoded grant, all-ones when no grant
module weighted_rr_arbiter
  import arb_pkg::*;
#(
  parameter int NumRequests = 8,
  parameter int WeightWidth = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               ce,
  input  logic [NumRequests-1:0]             req,
  input  logic [NumRequests-1:0]             lock,
  input  logic [NumRequests*WeightWidth-1:0] weight,
  input  logic                               ack,
  output logic                               grant_valid,
  output logic [NumRequests-1:0]             grant,
  output logic [$clog2(NumRequests):0]       grant_enc
);

  localparam int N  = NumRequests;
  localparam int W  = WeightWidth;
  localparam int EW = $clog2(NumRequests) + 1;

  arb_state_e     state_q, state_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [N-1:0]   mask_q, mask_d;
  logic [W-1:0]   credit_q, credit_d;
  logic [EW-1:0]  enc_q, enc_d;
  logic           valid_q, valid_d;

  logic           owner_req, owner_lock, release_now;
  logic [N-1:0]   upto_owner, release_mask;
  logic [N-1:0]   pick_req, pick_mask, masked_req;
  logic [N-1:0]   m_onehot, u_onehot, winner_oh;
  logic [EW-1:0]  m_enc, u_enc, winner_enc;
  logic           m_valid, u_valid;
  logic [W-1:0]   winner_w, credit_load;

  assign owner_req  = |(req & grant_q);
  assign owner_lock = |(lock & grant_q);

  // Bits 0..owner set; its complement is the rotated priority mask.
  assign upto_owner   = {grant_q[N-2:0], 1'b0} - N'(1);
  assign release_mask = ~upto_owner;

  assign release_now = (state_q == GRANTED) && !owner_lock &&
                       ((ack && (credit_q == W'(1))) || !owner_req);

  // On release the outgoing owner is excluded and the new mask applies in the same edge,
  // so a lone owner always passes through IDLE before being re-granted.
  assign pick_req   = (state_q == GRANTED) ? (req & ~grant_q) : req;
  assign pick_mask  = (state_q == GRANTED) ? release_mask : mask_q;
  assign masked_req = pick_req & pick_mask;

  priority_pick #(.N(N)) u_pick_masked (
    .req_i    (masked_req),
    .onehot_o (m_onehot),
    .enc_o    (m_enc),
    .valid_o  (m_valid)
  );

  priority_pick #(.N(N)) u_pick_unmasked (
    .req_i    (pick_req),
    .onehot_o (u_onehot),
    .enc_o    (u_enc),
    .valid_o  (u_valid)
  );

  assign winner_oh  = m_valid ? m_onehot : u_onehot;
  assign winner_enc = m_valid ? m_enc : u_enc;

  always_comb begin
    winner_w = '0;
    for (int i = 0; i < N; i++) begin
      if (winner_oh[i]) begin
        winner_w = winner_w | weight[i*W +: W];
      end
    end
  end

  assign credit_load = W'(weff(32'(winner_w)));

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    mask_d   = mask_q;
    credit_d = credit_q;
    enc_d    = enc_q;
    valid_d  = valid_q;
    case (state_q)
      IDLE: begin
        if (u_valid) begin
          state_d  = GRANTED;
          grant_d  = winner_oh;
          enc_d    = winner_enc;
          credit_d = credit_load;
          valid_d  = 1'b1;
        end
      end
      GRANTED: begin
        if (release_now) begin
          mask_d = release_mask;
          if (u_valid) begin
            grant_d  = winner_oh;
            enc_d    = winner_enc;
            credit_d = credit_load;
          end else begin
            state_d  = IDLE;
            grant_d  = '0;
            enc_d    = '1;
            credit_d = '0;
            valid_d  = 1'b0;
          end
        end else if (ack && (credit_q > W'(1))) begin
          // Under lock the credit bottoms out at one instead of releasing.
          credit_d = credit_q - W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      mask_q   <= '1;
      credit_q <= '0;
      enc_q    <= '1;
      valid_q  <= 1'b0;
    end else if (ce) begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      mask_q   <= mask_d;
      credit_q <= credit_d;
      enc_q    <= enc_d;
      valid_q  <= valid_d;
    end
  end

  assign grant       = grant_q;
  assign grant_enc   = enc_q;
  assign grant_valid = valid_q;

endmodule

// File: tb/tb_weighted_rr_arbiter.sv
// tb/tb_weighted_rr_arbiter.sv - scoreboard bench for weighted_rr_arbiter
module tb_weighted_rr_arbiter;

  localparam int N  = 8;
  localparam int W  = 4;
  localparam int EW = 4;

  logic           clk = 1'b0;
  logic           rst, ce, ack, grant_valid;
  logic [N-1:0]   req, lock, grant;
  logic [N*W-1:0] weight;
  logic [EW-1:0]  grant_enc;

  typedef struct {
    logic [N-1:0] g;
    string        name;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  weighted_rr_arbiter #(.NumRequests(N), .WeightWidth(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .ce          (ce),
    .req         (req),
    .lock        (lock),
    .weight      (weight),
    .ack         (ack),
    .grant_valid (grant_valid),
    .grant       (grant),
    .grant_enc   (grant_enc)
  );

  always #5 clk = ~clk;

  function automatic logic [EW-1:0] enc_of(input logic [N-1:0] g);
    logic [EW-1:0] r;
    r = '1;
    for (int i = N - 1; i >= 0; i--) if (g[i]) r = EW'(i);
    return r;
  endfunction

  function automatic logic [N*W-1:0] wts(input int w0, input int w1, input int w2);
    logic [N*W-1:0] w;
    for (int i = 0; i < N; i++) w[i*W +: W] = W'(1);
    w[0 +: W] = W'(w0);
    w[W +: W] = W'(w1);
    w[2*W +: W] = W'(w2);
    return w;
  endfunction

  // Drive one cycle of stimulus and queue the grant expected after the next edge.
  task automatic step(input string nm, input logic c, input logic [N-1:0] rq,
                      input logic a, input logic [N-1:0] lk, input logic [N-1:0] eg);
    exp_t e;
    @(negedge clk);
    rst = 1'b0; ce = c; req = rq; ack = a; lock = lk;
    e.g = eg; e.name = nm;
    q.push_back(e);
  endtask

  task automatic reset_step(input string nm, input logic [N*W-1:0] w, input logic [N-1:0] rq);
    exp_t e;
    @(negedge clk);
    rst = 1'b1; ce = 1'b1; req = rq; ack = 1'b0; lock = '0; weight = w;
    e.g = '0; e.name = nm;
    q.push_back(e);
  endtask

  // Monitor: compares the presented grant against the oldest queued expectation.
  exp_t          cur;
  logic [EW-1:0] cur_enc;
  always begin
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      cur = q.pop_front();
      cur_enc = enc_of(cur.g);
      total++;
      if (grant !== cur.g || grant_valid !== (|cur.g) || grant_enc !== cur_enc) begin
        bad++;
        $display("FAIL %s: got grant=%h valid=%b enc=%h, want grant=%h valid=%b enc=%h",
                 cur.name, grant, grant_valid, grant_enc, cur.g, |cur.g, cur_enc);
      end
    end
  end

  initial begin
    rst = 1'b1; ce = 1'b1; req = '0; ack = 1'b0; lock = '0; weight = wts(1, 1, 1);

    // Reset with all requests high, then first grant one cycle later.
    reset_step("rst0", wts(1, 1, 1), 8'hFF);
    reset_step("rst1", wts(1, 1, 1), 8'hFF);
    step("first_grant", 1, 8'hFF, 0, 8'h00, 8'h01);
    step("drop_to_idle", 1, 8'h00, 0, 8'h00, 8'h00);

    // Equal weights, back-to-back rotation.
    reset_step("eq_rst", wts(1, 1, 1), 8'h00);
    step("eq_g0", 1, 8'h07, 1, 8'h00, 8'h01);
    step("eq_g1", 1, 8'h07, 1, 8'h00, 8'h02);
    step("eq_g2", 1, 8'h07, 1, 8'h00, 8'h04);
    step("eq_wrap0", 1, 8'h07, 1, 8'h00, 8'h01);
    step("eq_g1b", 1, 8'h07, 1, 8'h00, 8'h02);

    // Weighted: w0=3, w1=0 (acts as 1).
    reset_step("wt_rst", wts(3, 0, 1), 8'h00);
    step("wt_a0", 1, 8'h03, 1, 8'h00, 8'h01);
    step("wt_a1", 1, 8'h03, 1, 8'h00, 8'h01);
    step("wt_a2", 1, 8'h03, 1, 8'h00, 8'h01);
    step("wt_b0", 1, 8'h03, 1, 8'h00, 8'h02);
    step("wt_c0", 1, 8'h03, 1, 8'h00, 8'h01);
    step("wt_c1", 1, 8'h03, 1, 8'h00, 8'h01);
    step("wt_c2", 1, 8'h03, 1, 8'h00, 8'h01);
    step("wt_d0", 1, 8'h03, 1, 8'h00, 8'h02);

    // Lock on requester 2 (weight 2) survives five acks; unlock with ack rotates.
    reset_step("lk_rst", wts(1, 1, 2), 8'h00);
    step("lk_grant", 1, 8'h04, 0, 8'h04, 8'h04);
    for (int i = 0; i < 5; i++) step("lk_hold", 1, 8'h0C, 1, 8'h04, 8'h04);
    step("lk_release", 1, 8'h0C, 1, 8'h00, 8'h08);

    // Early release: req[0] drops after one ack, requester 5 takes over.
    reset_step("er_rst", wts(4, 1, 1), 8'h00);
    step("er_g0", 1, 8'h21, 0, 8'h00, 8'h01);
    step("er_ack", 1, 8'h21, 1, 8'h00, 8'h01);
    step("er_g5", 1, 8'h20, 0, 8'h00, 8'h20);

    // Clock enable freezes credit; idle afterwards.
    reset_step("ce_rst", wts(3, 1, 1), 8'h00);
    step("ce_g0", 1, 8'h03, 0, 8'h00, 8'h01);
    step("ce_ack1", 1, 8'h03, 1, 8'h00, 8'h01);
    for (int i = 0; i < 3; i++) step("ce_frozen", 0, 8'h03, 1, 8'h00, 8'h01);
    step("ce_ack2", 1, 8'h03, 1, 8'h00, 8'h01);
    step("ce_rotate", 1, 8'h03, 1, 8'h00, 8'h02);
    step("ce_idle", 1, 8'h00, 0, 8'h00, 8'h00);
    step("idle_ack", 1, 8'h00, 1, 8'h00, 8'h00);

    // Lone requester with expired credit re-granted after a one-cycle bubble.
    reset_step("bb_rst", wts(1, 1, 1), 8'h00);
    step("bb_g0", 1, 8'h01, 1, 8'h00, 8'h01);
    step("bb_bubble", 1, 8'h01, 1, 8'h00, 8'h00);
    step("bb_regrant", 1, 8'h01, 1, 8'h00, 8'h01);

    // Let the monitor drain the final expectation.
    @(posedge clk);
    #2;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d required=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/weighted_rr_arbiter.md
Name: weighted_rr_arbiter

Overview:
- Registered, weighted round-robin arbiter with grant hold and per-requester lock.
- A winner keeps the grant for up to weight[i] accepted transfers (ack pulses), then rotates priority past itself.
- Placed in front of shared buses and memory ports where requesters burst, and where some requesters need a larger bandwidth share.
- Generalises the single-cycle round-robin arbiter with configurable weights, a credit counter, a lock and an ack handshake.

Parameters:
- NumRequests, 8, number of requesters (2..64).
- WeightWidth, 4, bits per weight / credit counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- ce  in  1  clock enable; all state frozen when low
- req  in  NumRequests  request per requester, level
- lock  in  NumRequests  lock[i] high while i is granted: hold grant regardless of credit
- weight  in  NumRequests*WeightWidth  static weight per requester; field i = weight[i*WeightWidth +: WeightWidth]
- ack  in  1  granted requester completed one transfer this cycle
- grant_valid  out  1  a grant is active
- grant  out  NumRequests  one-hot grant, registered
- grant_enc  out  $clog2(NumRequests)+1  encoded grant; all-ones when grant_valid=0

Behaviour:
- Reset values (while rst=1 at an edge):
  - grant=0, grant_valid=0, grant_enc=all-ones
  - credit=0
  - ptr mask=all-ones (requester 0 has highest priority)
  - state=IDLE
- All outputs are registered; there is no combinational path from req/ack to grant.
- Effective weight = weight[i], but 0 is treated as 1.
- Selection (combinational, internal):
  - masked = req & mask.
  - Winner = lowest set bit of masked if masked≠0, else lowest set bit of req.
- State IDLE, on a ce edge with any req set:
  - grant <= winner, grant_valid <= 1, credit <= effective weight of winner, state <= GRANTED.
  - Arbitration latency is 1 cycle from req to grant.
- State GRANTED, owner g. Release occurs when either:
  - ack & credit==1 & ~lock[g], or
  - ~req[g] & ~lock[g].
- Credit accounting in GRANTED:
  - On ack without release, credit decrements.
  - Under lock, credit saturates at 1: it never goes to 0 and the grant persists.
  - ack when credit==1 and lock[g]=1: no release; credit stays 1.
- On release:
  - mask <= bits above g only (bits 0..g cleared).
  - Re-arbitrate in the same edge using req with req[g] excluded and the new mask applied.
  - If another requester wins: grant moves to it directly (back-to-back, no bubble), with a fresh credit load.
  - If no other requester is pending: grant <= 0, grant_valid <= 0, state <= IDLE.
- Requester g alone and still requesting after credit expires: re-granted with a 1-cycle bubble via IDLE, so other requesters never wait more than one rotation.
- ack while grant_valid=0: ignored.
- req[g] dropping in the same cycle as ack: counts as release; the ack is consumed.
- lock bits of non-granted requesters: ignored.
- ce=0: no state, credit, mask or output change. rst overrides ce.
- Fairness bound: a continuously requesting requester waits at most the sum of the other requesters' effective weights in acked transfers. Lock suspends this bound.
- Invariants:
  - grant is one-hot or zero.
  - grant_valid == |grant.
  - grant_enc is consistent with grant.

Decomposition:
- Package arb_pkg:
  - typedef arb_state_e {IDLE, GRANTED}
  - function weff(w): returns 1 for w=0, else w.
- Sub-module priority_pick: lowest-set-bit picker with one-hot and encoded outputs.
  - Instantiated twice: masked and unmasked.
  - Encoded output is all-ones when its input is zero.
- Top holds the state register, credit counter, mask and output registers.

Test Plan:
- Reset: assert rst 2 cycles with req=8'hFF -> grant=0, grant_valid=0, grant_enc=4'hF. First post-reset edge -> grant=8'h01.
- Equal weights: all weights 1, req=8'b0000_0111, ack every cycle -> grant sequence 0x01,0x02,0x04,0x01 with no bubbles.
- Weighted: weight0=3, weight1=1, req=8'b11, ack always -> grant 0x01 for 3 cycles, then 0x02 for 1 cycle, repeat. Weight 0 on requester 1 behaves as 1.
- Lock: requester 2 granted with weight 2, lock[2]=1, 5 acks -> grant stays 0x04, credit holds at 1. Drop lock with ack -> rotates to next requester (req 0x0C gives 0x08).
- Early release: requester 0 granted with weight 4, req[0] drops after 1 ack, req[5] high -> next edge grant=0x20, grant_enc=5.
- ce and idle: ce=0 for 3 cycles mid-grant with acks -> no grant or credit change. Req all zero after release -> grant_valid=0, grant_enc all-ones.
